// File: rtl/bcd_pkg.sv
// Shared types and constants for the BCD step generator and its digit cells.
// Digits are 4-bit codes; legal values are 0..BCD_MAX.
package bcd_pkg;

    typedef logic [3:0] digit_t;

    localparam digit_t BCD_MAX = 4'd9;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESENT = 2'd1,
        WAIT    = 2'd2
    } state_t;

    function automatic logic digit_illegal(input digit_t d);
        return d > BCD_MAX;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One registered decimal digit of the counter chain.
// It steps only when cin is high, and ripples a carry/borrow to the next digit through cout.
module bcd_digit
    import bcd_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   load,
    input  digit_t load_d,
    input  logic   inc,
    input  logic   dec,
    input  logic   cin,
    output logic   cout,
    output digit_t q
);

    digit_t q_reg;
    digit_t q_next;

    // cout is high when this digit rolls over in the current step direction.
    assign cout = cin & ((inc & (q_reg == BCD_MAX)) | (~inc & dec & (q_reg == '0)));

    always_comb begin
        q_next = q_reg;
        if (load) begin
            q_next = load_d;
        end else if (cin && inc) begin
            q_next = (q_reg == BCD_MAX) ? '0 : q_reg + 4'd1;
        end else if (cin && dec) begin
            q_next = (q_reg == '0) ? BCD_MAX : q_reg - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_reg <= '0;
        end else begin
            q_reg <= q_next;
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/bcd_step_gen.sv
// Sequenced BCD source with a valid/ready output, decimal up/down counting,
// programmable spacing between values, and a range-checked parallel load.
module bcd_step_gen
    import bcd_pkg::*;
#(
    parameter int NDIG = 1,
    parameter int DIV  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              up,
    input  logic              load,
    input  logic [4*NDIG-1:0] load_val,
    output logic [4*NDIG-1:0] bcd,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              wrap,
    output logic              load_err
);

    localparam int            PW         = $clog2(DIV) + 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

    state_t          state_reg;
    state_t          state_next;
    logic [PW-1:0]   presc_reg;
    logic [PW-1:0]   presc_next;
    logic [PW-1:0]   presc_step;
    logic            wrap_reg;
    logic            load_err_reg;

    logic            handshake;
    logic            load_window;
    logic            load_accept;
    logic            load_reject;
    logic [NDIG:0]   carry;
    logic [NDIG-1:0] digit_bad;

    assign handshake   = (state_reg == PRESENT) && out_ready;
    assign load_window = load && (state_reg != PRESENT);
    assign load_accept = load_window && !(|digit_bad);
    assign load_reject = load_window && (|digit_bad);
    assign presc_step  = presc_reg + PW'(1);

    // The chain only steps on a handshake, so a load and an advance never collide.
    assign carry[0] = handshake;

    generate
        for (genvar gi = 0; gi < NDIG; gi++) begin : g_digit
            digit_t digit_q;

            assign digit_bad[gi] = digit_illegal(load_val[4*gi +: 4]);

            bcd_digit u_digit (
                .clk    (clk),
                .rst_n  (rst_n),
                .load   (load_accept),
                .load_d (load_val[4*gi +: 4]),
                .inc    (up),
                .dec    (~up),
                .cin    (carry[gi]),
                .cout   (carry[gi+1]),
                .q      (digit_q)
            );

            assign bcd[4*gi +: 4] = digit_q;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            presc_reg    <= '0;
            wrap_reg     <= 1'b0;
            load_err_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            presc_reg    <= presc_next;
            wrap_reg     <= handshake && carry[NDIG];
            load_err_reg <= load_reject;
        end
    end

    // A load while waiting restarts the spacing interval from zero.
    always_comb begin
        state_next = state_reg;
        presc_next = '0;
        case (state_reg)
            IDLE: begin
                if (en) begin
                    state_next = PRESENT;
                end
            end
            PRESENT: begin
                if (handshake) begin
                    if (!en) begin
                        state_next = IDLE;
                    end else if (DIV == 1) begin
                        state_next = PRESENT;
                    end else begin
                        state_next = WAIT;
                    end
                end
            end
            WAIT: begin
                presc_next = load_accept ? '0 : presc_step;
                if (!en) begin
                    state_next = IDLE;
                end else if (load_accept) begin
                    state_next = WAIT;
                end else if (presc_step == PRESC_LAST) begin
                    state_next = PRESENT;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        out_valid = (state_reg == PRESENT);
    end

    assign wrap     = wrap_reg;
    assign load_err = load_err_reg;

endmodule

// File: doc/bcd_step_gen.md
# bcd_step_gen

Sequenced BCD source that sits directly upstream of the BCD-to-Gray converter. It produces a stream of legal BCD values (0–9 per digit) and presents them on `bcd` with a valid/ready handshake. It counts up or down with decimal carry/borrow across `NDIG` digits, supports a programmable inter-value spacing and a checked parallel load. Its `bcd` output drives the combinational converter directly, so it is stable whenever `out_valid` is high.

## Interface
- `NDIG`, 1: number of BCD digits; `bcd` width is 4*NDIG.
- `DIV`, 1: cycles from accepted transfer to next `out_valid`; must be ≥1.

- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `en`  in  1  run enable.
- `up`  in  1  direction: 1 = count up, 0 = count down; sampled at the handshake.
- `load`  in  1  parallel-load request.
- `load_val`  in  4*NDIG  value to load; digit[3:0] is the least significant digit.
- `bcd`  out  4*NDIG  current BCD value, registered.
- `out_valid`  out  1  `bcd` is offered downstream.
- `out_ready`  in  1  downstream accepts.
- `wrap`  out  1  one-cycle pulse on a modulo wrap.
- `load_err`  out  1  one-cycle pulse when a load is rejected.

## Operation
- Reset (`rst_n`=0 at an edge): `bcd`=0, `out_valid`=0, `wrap`=0, `load_err`=0, prescaler=0, state=IDLE. This applies from any state, including mid-transfer.
- States:
  - IDLE: `out_valid`=0. `en`=1 → PRESENT.
  - PRESENT: `out_valid`=1 and `bcd` held stable.
  - WAIT: `out_valid`=0 while the prescaler counts DIV-1 cycles.
- Handshake in PRESENT (`out_valid`&`out_ready`): the counter advances by ±1 per `up`.
  - If `en`=0 → IDLE.
  - Else if DIV=1 → stay in PRESENT with the new value.
  - Else → WAIT.
- WAIT: when the prescaler reaches DIV-1 → PRESENT. `en`=0 → IDLE.
- No retraction: once `out_valid` rises, it and `bcd` hold until a handshake, even if `en` drops.
- Arithmetic: per-digit ripple.
  - Up: 9→0 with carry.
  - Down: 0→9 with borrow.
  - Carry/borrow out of the top digit is discarded and sets `wrap`=1 for the cycle after the handshake. Wrap cases: all-9s→0 counting up, 0→all-9s counting down.
- Load: accepted only while `out_valid`=0 (IDLE or WAIT); ignored in PRESENT.
  - If any digit of `load_val` is >9: the load is rejected, `load_err` pulses for 1 cycle, and `bcd` is unchanged.
  - Valid load: `bcd`←`load_val` at the next edge, the prescaler clears to 0, and the state is otherwise unchanged.
  - `load`+`en` together in IDLE: the load and the IDLE→PRESENT move share one edge, so the first presented value is `load_val`.
- The first value after IDLE→PRESENT is the current `bcd` (no advance, no prescale).

## Timing
- `en` rise in IDLE → `out_valid`=1 at the next edge.
- Handshake → next `out_valid`=1 after exactly DIV cycles. DIV=1 gives one value per cycle with `out_valid` continuously high.
- `bcd` changes only at:
  - a handshake edge,
  - an accepted load,
  - reset.
- `wrap` and `load_err` are registered, 1-cycle pulses, and never last 2 consecutive cycles from one event.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package `bcd_pkg`:
  - 4-bit digit type,
  - `BCD_MAX`=4'd9,
  - state enum {IDLE, PRESENT, WAIT}.
- Sub-module `bcd_digit`: a single digit with `inc`, `dec`, `cin`, `cout`, `q`. Instantiate NDIG times in a carry chain.
- The top level holds the FSM, the prescaler (width `$clog2(DIV)`+1), load check, and pulse registers.

## Test plan
- NDIG=1, DIV=1, up=1, `out_ready`=1, `en`=1 after reset → `bcd` 0,1,…,9,0 on consecutive cycles; `wrap`=1 only in the cycle `bcd` returns to 0.
- Load 4'd0 in IDLE, up=0, `en`=1 → presents 0, then 9 with `wrap`=1, then 8.
- Backpressure at `bcd`=4: `out_ready`=0 for 3 cycles and `en` dropped in cycle 2 → `bcd`=4 and `out_valid`=1 held; on the `out_ready` pulse, advance to 5 and go to IDLE (`out_valid`=0).
- Load 4'b1010 in IDLE → `load_err`=1 for 1 cycle, `bcd` unchanged. `load` asserted while in PRESENT → ignored, no `load_err`.
- NDIG=2, load 8'h98, up → 98, 99, 00 with `wrap` pulse. Load 8'h9A → rejected.
- DIV=3, `out_ready`=1 → `out_valid` pattern 1,0,0,1,0,0. Assert `rst_n`=0 while in PRESENT with `bcd`=7 → next edge `bcd`=0, `out_valid`=0, state IDLE.
